fma_sign_pipe: RTL and testbench

- Multi-lane, pipelined sign resolver for the vector FMA path (result = ±(a·b) ± c).
- Stage 0 computes, per lane, the tentative sign s_tmp, the effective-subtract flag and the final mask. It supports all four FMA op variants.
- A stall-aware delay line holds these per-lane values until the mantissa adder result arrives DELAY cycles later.
- It then resolves the final result sign, including the sign of an exact-zero result.

---
 rtl/vfpu_pkg.sv | 31 +++
 rtl/sign_delay_stage.sv | 68 ++++++
 rtl/fma_sign_pipe.sv | 135 +++++++++++++
 tb/tb_fma_sign_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfpu_pkg.sv
// Shared encodings and per-lane sign record for the vector FPU sign path.
// FMA_SIGN_RM_ZERO_EN selects whether exact-zero differences honour the rounding mode.
package vfpu_pkg;

    typedef enum logic [1:0] {
        OP_FMA  = 2'b00,
        OP_FMS  = 2'b01,
        OP_FNMA = 2'b10,
        OP_FNMS = 2'b11
    } fma_op_e;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } round_mode_e;

    typedef struct packed {
        logic s_tmp;
        logic final_m;
        logic lane_en;
    } sign_info_t;

    // IEEE 754: x - x is +0 in every rounding mode except round-down, which gives -0.
    function automatic logic zeroResultSign(input logic [2:0] rmIn);
        return rmIn == RM_RDN;
    endfunction

endpackage

// File: rtl/sign_delay_stage.sv
// One stall/flush-aware register stage of the sign delay line (valid bit + per-lane sign info).
// With FMA_SIGN_RM_ZERO_EN defined the stage also carries the rounding mode.
module sign_delay_stage
    import vfpu_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  sign_info_t [LANES-1:0] info_i,
`ifdef FMA_SIGN_RM_ZERO_EN
    input  logic [2:0]             rm_i,
    output logic [2:0]             rm_o,
`endif
    output logic                   valid_o,
    output sign_info_t [LANES-1:0] info_o
);

    logic                   valid_d, valid_q;
    sign_info_t [LANES-1:0] info_d, info_q;
`ifdef FMA_SIGN_RM_ZERO_EN
    logic [2:0]             rm_d, rm_q;
`endif

    // Flush only kills the valid bit; the payload is don't-care once invalid.
    always_comb begin
        valid_d = valid_q;
        info_d  = info_q;
`ifdef FMA_SIGN_RM_ZERO_EN
        rm_d    = rm_q;
`endif
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!stall_i) begin
            valid_d = valid_i;
            info_d  = info_i;
`ifdef FMA_SIGN_RM_ZERO_EN
            rm_d    = rm_i;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            info_q  <= '0;
`ifdef FMA_SIGN_RM_ZERO_EN
            rm_q    <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            info_q  <= info_d;
`ifdef FMA_SIGN_RM_ZERO_EN
            rm_q    <= rm_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign info_o  = info_q;
`ifdef FMA_SIGN_RM_ZERO_EN
    assign rm_o    = rm_q;
`endif

endmodule

// File: rtl/fma_sign_pipe.sv
// Multi-lane pipelined sign resolver for the vector FMA path: result = +/-(a*b) +/- c.
// Define FMA_SIGN_RM_ZERO_EN to give exact-zero differences a -0 sign under RDN.
module fma_sign_pipe
    import vfpu_pkg::*;
#(
    parameter int LANES = 4,
    parameter int DELAY = 3,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [OPW-1:0]   op,
    input  logic [2:0]       rm,
    input  logic [LANES-1:0] lane_en,
    input  logic [LANES-1:0] sa,
    input  logic [LANES-1:0] sb,
    input  logic [LANES-1:0] sc,
    output logic [LANES-1:0] eff_sub,
    input  logic [LANES-1:0] sum_neg,
    input  logic [LANES-1:0] sum_zero,
    output logic             out_valid,
    output logic [LANES-1:0] s_final,
    output logic             busy
);

    logic [LANES-1:0]       prodSign;
    logic [LANES-1:0]       addSign;
    logic [LANES-1:0]       effSubNow;
    sign_info_t [LANES-1:0] capInfo;

    // op[1] negates the product, op[0] negates the addend.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prodSign[i]        = sa[i] ^ sb[i] ^ op[1];
            addSign[i]         = sc[i] ^ op[0];
            effSubNow[i]       = prodSign[i] ^ addSign[i];
            capInfo[i].s_tmp   = prodSign[i];
            capInfo[i].final_m = ~effSubNow[i];
            capInfo[i].lane_en = lane_en[i];
        end
    end

    logic [LANES-1:0] effSub_d, effSub_q;

    assign effSub_d = (stall || flush) ? effSub_q : (effSubNow & lane_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            effSub_q <= '0;
        end else begin
            effSub_q <= effSub_d;
        end
    end

    assign eff_sub = effSub_q;

    logic [DELAY:0]         validChain;
    sign_info_t [LANES-1:0] infoChain [0:DELAY];
`ifdef FMA_SIGN_RM_ZERO_EN
    logic [2:0]             rmChain [0:DELAY];
    assign rmChain[0] = rm;
`endif

    assign validChain[0] = in_valid;
    assign infoChain[0]  = capInfo;

    for (genvar g = 0; g < DELAY; g++) begin : gStage
        sign_delay_stage #(
            .LANES (LANES)
        ) uStage (
            .clk_i   (clk),
            .rst_i   (rst),
            .stall_i (stall),
            .flush_i (flush),
            .valid_i (validChain[g]),
            .info_i  (infoChain[g]),
`ifdef FMA_SIGN_RM_ZERO_EN
            .rm_i    (rmChain[g]),
            .rm_o    (rmChain[g+1]),
`endif
            .valid_o (validChain[g+1]),
            .info_o  (infoChain[g+1])
        );
    end

    sign_info_t [LANES-1:0] outInfo;
    logic                   outZeroSign;

    assign outInfo = infoChain[DELAY];

`ifdef FMA_SIGN_RM_ZERO_EN
    assign outZeroSign = zeroResultSign(rmChain[DELAY]);
`else
    logic unusedRm;
    assign unusedRm    = ^rm;
    assign outZeroSign = 1'b0;
`endif

    logic [LANES-1:0] sFinal_d, sFinal_q;

    // An effective add keeps the product sign even for 0+0; a subtraction flips on a
    // negative magnitude difference, and an exact zero takes the rounding-mode sign.
    always_comb begin
        sFinal_d = sFinal_q;
        if (validChain[DELAY] && !stall && !flush) begin
            for (int i = 0; i < LANES; i++) begin
                if (!outInfo[i].lane_en) begin
                    sFinal_d[i] = 1'b0;
                end else if (outInfo[i].final_m) begin
                    sFinal_d[i] = outInfo[i].s_tmp;
                end else if (!sum_zero[i]) begin
                    sFinal_d[i] = outInfo[i].s_tmp ^ sum_neg[i];
                end else begin
                    sFinal_d[i] = outZeroSign;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sFinal_q <= '0;
        end else begin
            sFinal_q <= sFinal_d;
        end
    end

    assign s_final   = sFinal_q;
    assign out_valid = validChain[DELAY];
    assign busy      = |validChain[DELAY:1];

endmodule

// File: tb/tb_fma_sign_pipe.sv
// Scoreboard bench for fma_sign_pipe: directed lane groups queue their expected sign at issue,
// a separate monitor checks them when out_valid shows. Follows FMA_SIGN_RM_ZERO_EN.
module tb_fma_sign_pipe;

    localparam int LANES = 4;
    localparam int DELAY = 3;
    localparam int OPW   = 2;

`ifdef FMA_SIGN_RM_ZERO_EN
    localparam logic [3:0] RDN_ZERO_EXP = 4'b0001;
`else
    localparam logic [3:0] RDN_ZERO_EXP = 4'b0000;
`endif

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             in_valid = 1'b0;
    logic             stall    = 1'b0;
    logic             flush    = 1'b0;
    logic [OPW-1:0]   op       = '0;
    logic [2:0]       rm       = '0;
    logic [LANES-1:0] lane_en  = '0;
    logic [LANES-1:0] sa       = '0;
    logic [LANES-1:0] sb       = '0;
    logic [LANES-1:0] sc       = '0;
    logic [LANES-1:0] sum_neg  = '0;
    logic [LANES-1:0] sum_zero = '0;
    logic [LANES-1:0] eff_sub;
    logic             out_valid;
    logic [LANES-1:0] s_final;
    logic             busy;

    fma_sign_pipe #(
        .LANES (LANES),
        .DELAY (DELAY),
        .OPW   (OPW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .op        (op),
        .rm        (rm),
        .lane_en   (lane_en),
        .sa        (sa),
        .sb        (sb),
        .sc        (sc),
        .eff_sub   (eff_sub),
        .sum_neg   (sum_neg),
        .sum_zero  (sum_zero),
        .out_valid (out_valid),
        .s_final   (s_final),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] rm;
        logic [3:0] en;
        logic [3:0] sa;
        logic [3:0] sb;
        logic [3:0] sc;
        logic [3:0] neg;
        logic [3:0] zero;
        logic [3:0] expS;
        logic [3:0] expEff;
    } vec_t;

    typedef struct {
        logic [3:0] expS;
        logic [3:0] neg;
        logic [3:0] zero;
        int         issueAdv;
    } exp_t;

    vec_t       vecs [11];
    exp_t       expQ [$];
    int         checks     = 0;
    int         errors     = 0;
    int         advCnt     = 0;
    logic       effPending = 1'b0;
    logic [3:0] effExp     = '0;

    // Counts clock edges the pipeline actually advanced on.
    always @(posedge clk) begin
        if (!stall) advCnt <= advCnt + 1;
    end

    function automatic vec_t mkVec(input logic [1:0] o, input logic [2:0] r,
                                   input logic [3:0] en, a, b, c, ng, zr, es, ee);
        vec_t v;
        v.op = o; v.rm = r; v.en = en; v.sa = a; v.sb = b; v.sc = c;
        v.neg = ng; v.zero = zr; v.expS = es; v.expEff = ee;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkEffPending();
        if (effPending) begin
            checkOutput("eff_sub", 32'(eff_sub), 32'(effExp));
            effPending = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic st, input logic fl, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        checkEffPending();
        in_valid = iv;
        stall    = st;
        flush    = fl;
        op       = v.op;
        rm       = v.rm;
        lane_en  = v.en;
        sa       = v.sa;
        sb       = v.sb;
        sc       = v.sc;
        if (iv && !st && !fl) begin
            e.expS     = v.expS;
            e.neg      = v.neg;
            e.zero     = v.zero;
            e.issueAdv = advCnt;
            expQ.push_back(e);
            effPending = 1'b1;
            effExp     = v.expEff;
        end
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        checkEffPending();
        rst      = 1'b1;
        stall    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_s_final", 32'(s_final), 32'd0);
        checkOutput("reset_eff_sub", 32'(eff_sub), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 40) begin
            applyStimulus(1'b0, 1'b0, 1'b0, vecs[0]);
            n++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, vecs[0]);
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    endtask

    initial begin : monitor
        logic       pending;
        logic       prevStall;
        logic       prevRst;
        logic [3:0] prevS;
        pending   = 1'b0;
        prevStall = 1'b0;
        prevRst   = 1'b1;
        prevS     = '0;
        forever begin
            @(negedge clk);
            if (prevStall && !prevRst) checkOutput("s_final_hold", 32'(s_final), 32'(prevS));
            if (pending) begin
                checkOutput("s_final", 32'(s_final), 32'(expQ[0].expS));
                void'(expQ.pop_front());
                pending = 1'b0;
            end
            if (rst || flush) begin
                expQ.delete();
            end else if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out: out_valid=%0b, required 0 with no group in flight", out_valid);
                end else begin
                    sum_neg  = expQ[0].neg;
                    sum_zero = expQ[0].zero;
                    if (!stall) begin
                        checkOutput("latency", 32'(advCnt - expQ[0].issueAdv), 32'(DELAY));
                        pending = 1'b1;
                    end
                end
            end
            prevStall = stall;
            prevRst   = rst;
            prevS     = s_final;
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got still running, required finished");
        $fatal(1);
    end

    initial begin : stimulus
        //                op     rm      en       sa       sb       sc       neg      zero     expS          expEff
        vecs[0]  = mkVec(2'b00, 3'b000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000,     4'b0000);
        vecs[1]  = mkVec(2'b00, 3'b000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001,     4'b0000);
        vecs[2]  = mkVec(2'b01, 3'b000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000,     4'b0001);
        vecs[3]  = mkVec(2'b01, 3'b000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001,     4'b0001);
        vecs[4]  = mkVec(2'b01, 3'b010, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, RDN_ZERO_EXP, 4'b0001);
        vecs[5]  = mkVec(2'b01, 3'b000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,     4'b0001);
        vecs[6]  = mkVec(2'b10, 3'b000, 4'b1111, 4'b0000, 4'b0000, 4'b0011, 4'b0100, 4'b0000, 4'b1011,     4'b1100);
        vecs[7]  = mkVec(2'b11, 3'b000, 4'b1111, 4'b0101, 4'b0011, 4'b1001, 4'b0011, 4'b0000, 4'b1010,     4'b1111);
        vecs[8]  = mkVec(2'b01, 3'b000, 4'b0101, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0101,     4'b0101);
        vecs[9]  = mkVec(2'b01, 3'b000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,     4'b0001);
        vecs[10] = mkVec(2'b00, 3'b010, 4'b0011, 4'b0011, 4'b0001, 4'b0010, 4'b0011, 4'b0011, 4'b0010,     4'b0000);

        applyReset();

        applyStimulus(1'b1, 1'b0, 1'b0, vecs[0]);
        drain();

        for (int i = 1; i < 11; i++) applyStimulus(1'b1, 1'b0, 1'b0, vecs[i]);
        drain();

        applyStimulus(1'b1, 1'b0, 1'b0, vecs[2]);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[3]);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[6]);
        applyStimulus(1'b1, 1'b1, 1'b0, vecs[7]);
        applyStimulus(1'b1, 1'b1, 1'b0, vecs[7]);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[7]);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[8]);
        drain();

        applyStimulus(1'b1, 1'b0, 1'b0, vecs[1]);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[4]);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[5]);
        applyStimulus(1'b1, 1'b1, 1'b1, vecs[0]);
        applyStimulus(1'b0, 1'b0, 1'b0, vecs[0]);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, vecs[0]);

        applyStimulus(1'b1, 1'b0, 1'b0, vecs[8]);
        drain();
        checkOutput("lane_mask_s_final", 32'(s_final), 32'h5);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[7]);
        applyStimulus(1'b1, 1'b0, 1'b0, vecs[6]);
        applyReset();

        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, vecs[0]);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
